seq_divider_2n_by_n: RTL and testbench

Multi-cycle restoring divider. It divides a 2N-digit base-2 dividend by an N-digit divisor and produces an N-digit quotient, an N-digit remainder and a no_div flag. It uses the same operand and result format as the combinational 4/2 divider and its feasibility checker. Operands are accepted through an soc/eoc handshake, and results are held registered until the next accepted start. It sits between the operand-producing datapath and the consumers of q/r, and replaces the combinational divider where the digit-count/area trade-off favours iteration.

---
 rtl/seq_divider_2n_by_n.sv | 158 +++++++++++++++
 tb/tb_seq_divider_2n_by_n.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_2n_by_n.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_2n_by_n
//  Description : Multi-cycle restoring divider. Divides a 2N-bit unsigned
//                dividend by an N-bit unsigned divisor, giving an N-bit
//                quotient, an N-bit remainder and an infeasibility flag.
//                One quotient bit is resolved per clock after a one-cycle
//                feasibility check.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock   in   1    system clock, rising-edge active
//    reset_  in   1    synchronous active-low reset
//    soc     in   1    start request (level), sampled only when idle
//    x       in   2N   dividend, captured on the start-accept edge
//    y       in   N    divisor, captured on the start-accept edge
//    eoc     out  1    1 = idle / result valid, 0 = division in progress
//    q       out  N    quotient (valid while eoc=1)
//    r       out  N    remainder (valid while eoc=1)
//    no_div  out  1    last division infeasible (y==0 or x[2N-1:N] >= y)
// ============================================================================
module seq_divider_2n_by_n #(
  parameter int N = 2
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           soc,
  input  logic [2*N-1:0] x,
  input  logic [N-1:0]   y,
  output logic           eoc,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           no_div
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [2*N-1:0] r_x;
  logic [N-1:0]   r_y;
  logic [N:0]     r_rem;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_qbits;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;
  logic           r_no_div;

  logic           w_infeasible;
  logic [N:0]     w_t;
  logic           w_ge;
  logic [N:0]     w_rem_nxt;
  logic [N-1:0]   w_qbits_nxt;

  // The quotient only fits in N bits when the high half of the dividend is
  // strictly below the divisor; this also rules out division by zero.
  assign w_infeasible = (r_y == '0) || (r_x[2*N-1:N] >= r_y);

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    w_t                = {r_rem[N-1:0], r_x[r_cnt]};
    w_ge               = (w_t >= {1'b0, r_y});
    w_rem_nxt          = w_ge ? (w_t - {1'b0, r_y}) : w_t;
    w_qbits_nxt        = r_qbits;
    w_qbits_nxt[r_cnt] = w_ge;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (soc) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_infeasible ? S_DONE : S_STEP;
      S_STEP:  if (r_cnt == '0) w_state_nxt = S_DONE;
      // Waiting for soc to drop makes a held-high soc start only one division.
      S_DONE:  if (!soc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_x      <= '0;
      r_y      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_qbits  <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_no_div <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (soc) begin
            r_x <= x;
            r_y <= y;
          end
        end
        S_CHECK: begin
          if (w_infeasible) begin
            r_q      <= '0;
            r_r      <= '0;
            r_no_div <= 1'b1;
          end else begin
            r_rem   <= {1'b0, r_x[2*N-1:N]};
            r_cnt   <= CW'(N - 1);
            r_qbits <= '0;
          end
        end
        S_STEP: begin
          r_rem   <= w_rem_nxt;
          r_qbits <= w_qbits_nxt;
          r_cnt   <= r_cnt - 1'b1;
          // Results are published only on the way into DONE so the outputs
          // keep the previous answer for the whole busy period.
          if (r_cnt == '0) begin
            r_q      <= w_qbits_nxt;
            r_r      <= w_rem_nxt[N-1:0];
            r_no_div <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign eoc    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign q      = r_q;
  assign r      = r_r;
  assign no_div = r_no_div;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_2n_by_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider_2n_by_n
//  Description : Self-checking bench for seq_divider_2n_by_n with one N=2 and
//                one N=4 instance, compared against an arithmetic reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider_2n_by_n;

  logic       clk;
  logic       rst_n;

  logic       soc2, eoc2, nd2;
  logic [3:0] x2;
  logic [1:0] y2, q2, r2;

  logic       soc4, eoc4, nd4;
  logic [7:0] x4;
  logic [3:0] y4, q4, r4;

  int n_checks;
  int n_fail;

  seq_divider_2n_by_n #(.N(2)) u_dut2 (
    .clock (clk), .reset_(rst_n), .soc(soc2), .x(x2), .y(y2),
    .eoc   (eoc2), .q(q2), .r(r2), .no_div(nd2)
  );

  seq_divider_2n_by_n #(.N(4)) u_dut4 (
    .clock (clk), .reset_(rst_n), .soc(soc4), .x(x4), .y(y4),
    .eoc   (eoc4), .q(q4), .r(r4), .no_div(nd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Plain arithmetic reference: quotient must fit in n bits and y nonzero.
  function automatic void ref_div(input int n, input int unsigned xv, input int unsigned yv,
                                  output int unsigned qe, output int unsigned re,
                                  output bit nde);
    nde = (yv == 0) || ((xv >> n) >= yv);
    if (nde) begin
      qe = 0;
      re = 0;
    end else begin
      qe = xv / yv;
      re = xv % yv;
    end
  endfunction

  // Start one division on the selected instance, scramble the operand inputs
  // after acceptance, wait for eoc and check results and busy length.
  task automatic do_div(input bit wide, input int unsigned xv, input int unsigned yv,
                        input string tag);
    int          n;
    int          busy;
    int unsigned qe, re;
    bit          nde;
    int unsigned qo, ro;
    bit          ndo, eo;
    n = wide ? 4 : 2;
    ref_div(n, xv, yv, qe, re, nde);
    @(negedge clk);
    if (wide) begin soc4 = 1'b1; x4 = xv[7:0]; y4 = yv[3:0]; end
    else      begin soc2 = 1'b1; x2 = xv[3:0]; y2 = yv[1:0]; end
    @(negedge clk);
    if (wide) begin soc4 = 1'b0; x4 = 8'($urandom); y4 = 4'($urandom); end
    else      begin soc2 = 1'b0; x2 = 4'($urandom); y2 = 2'($urandom); end
    busy = 0;
    eo   = wide ? eoc4 : eoc2;
    while (!eo && busy < 50) begin
      busy++;
      @(negedge clk);
      eo = wide ? eoc4 : eoc2;
    end
    if (!eo) check({tag, "_timeout"}, 0, 1);
    qo  = wide ? q4  : 32'(q2);
    ro  = wide ? r4  : 32'(r2);
    ndo = wide ? nd4 : nd2;
    check({tag, "_busy"}, busy, nde ? 1 : n + 1);
    check({tag, "_q"}, qo, qe);
    check({tag, "_r"}, ro, re);
    check({tag, "_nodiv"}, ndo, nde);
    if (!ndo) begin
      check({tag, "_qyr"}, qo * yv + ro, xv);
      check({tag, "_rlty"}, (ro < yv) ? 1 : 0, 1);
    end
  endtask

  initial begin
    int falls;
    bit prev;
    int unsigned xr, yr;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    soc2 = 1'b0; x2 = '0; y2 = '0;
    soc4 = 1'b0; x4 = '0; y4 = '0;
    repeat (2) @(negedge clk);
    check("rst_eoc2", eoc2, 1);
    check("rst_q2", q2, 0);
    check("rst_r2", r2, 0);
    check("rst_nd2", nd2, 0);
    check("rst_eoc4", eoc4, 1);
    check("rst_q4", q4, 0);
    rst_n = 1'b1;

    // Directed cases
    do_div(0, 11, 3, "n2_11_3");
    do_div(0, 12, 3, "n2_12_3");
    do_div(0, 5, 0, "n2_5_0");
    do_div(1, 200, 15, "n4_200_15");
    do_div(1, 0, 1, "n4_0_1");
    do_div(1, 255, 15, "n4_255_15");
    do_div(1, 239, 15, "n4_239_15");

    // Exhaustive N=2
    for (int xi = 0; xi < 16; xi++)
      for (int yi = 0; yi < 4; yi++)
        do_div(0, xi, yi, "n2_exh");

    // Random N=4, half of them forced feasible
    for (int k = 0; k < 60; k++) begin
      if (k % 2 == 0) begin
        yr = $urandom_range(1, 15);
        xr = ($urandom_range(0, yr - 1) << 4) | $urandom_range(0, 15);
      end else begin
        xr = $urandom_range(0, 255);
        yr = $urandom_range(0, 15);
      end
      do_div(1, xr, yr, "n4_rand");
    end

    // soc held high: exactly one division, DONE holds its result
    @(negedge clk);
    soc2 = 1'b1; x2 = 4'd11; y2 = 2'd3;
    falls = 0;
    prev  = eoc2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prev && !eoc2) falls++;
      prev = eoc2;
      if (i == 10) begin x2 = 4'd0; y2 = 2'd1; end
    end
    check("hold_starts", falls, 1);
    check("hold_eoc", eoc2, 1);
    check("hold_q", q2, 3);
    check("hold_r", r2, 2);
    soc2 = 1'b0;
    @(negedge clk);
    check("hold_idle_eoc", eoc2, 1);
    check("hold_idle_q", q2, 3);
    do_div(0, 7, 2, "n2_restart");

    // Reset in the middle of a division
    do_div(0, 11, 3, "n2_pre_rst");
    @(negedge clk);
    soc2 = 1'b1; x2 = 4'd10; y2 = 2'd3;
    @(negedge clk);
    soc2 = 1'b0;
    @(negedge clk);
    check("mid_busy", eoc2, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_eoc", eoc2, 1);
    check("mid_rst_q", q2, 0);
    check("mid_rst_r", r2, 0);
    check("mid_rst_nd", nd2, 0);
    @(negedge clk);
    check("mid_rst_stays_idle", eoc2, 1);
    do_div(0, 9, 2, "n2_9_2");
    do_div(0, 7, 2, "n2_7_2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
